// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queues 32-bit instruction words and issues them one at a time
// to a processor, waiting for done with a timeout watchdog.
module cmd_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              cmd_in,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     start,
    input  logic                     halt,
    input  logic                     clear_err,
    output logic [31:0]              command,
    output logic                     run,
    input  logic                     done,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [15:0]              issued_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERROR} state_t;

    state_t        state_q, state_d;
    logic          go_q, go_d;
    logic [31:0]   cmd_q, cmd_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [31:0]   mem_q [DEPTH];
    logic          push, pop, can_load, full;

    assign full         = level_q == (AW+1)'(DEPTH);
    assign cmd_ready    = !reset && !full;
    assign push         = cmd_valid && cmd_ready;
    assign can_load     = go_q && level_q != '0;
    assign timer_inc    = timer_q + 1'b1;
    assign command      = cmd_q;
    assign run          = state_q == ISSUE;
    assign busy         = state_q == ISSUE || state_q == WAIT;
    assign timeout_err  = state_q == ERROR;
    assign issued_count = cnt_q;
    assign fifo_level   = level_q;

    always_comb begin
        state_d = state_q;
        go_d    = halt ? 1'b0 : (start ? 1'b1 : go_q);
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (can_load) begin
                pop     = 1'b1;
                cmd_d   = mem_q[rd_ptr_q];
                state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
                timer_d = '0;
            end
            WAIT: if (done) begin
                cnt_d   = cnt_q + 16'd1;
                pop     = can_load;
                cmd_d   = can_load ? mem_q[rd_ptr_q] : cmd_q;
                state_d = can_load ? ISSUE : IDLE;
            end else begin
                // the watchdog fires on the edge where the timer would reach TIMEOUT-1
                timer_d = timer_inc;
                state_d = timer_inc == TW'(TIMEOUT - 1) ? ERROR : WAIT;
            end
            ERROR: if (clear_err) begin
                state_d = IDLE;
                go_d    = 1'b0;
            end
        endcase
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            go_q     <= 1'b0;
            cmd_q    <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            go_q     <= go_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end
endmodule
